// File: rtl/evg_hw_event_encoder.sv
// evg_hw_event_encoder: synchronizes trigger lines, queues rising edges and
// issues their table-mapped event codes round-robin on an AXI-stream output.
module evg_hw_event_encoder #(
    parameter int TRIGGER_COUNT = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             evgTxClk,
    input  logic                             evgTxReset,
    input  logic [TRIGGER_COUNT-1:0]         triggers,
    input  logic                             cfgWrite,
    input  logic [$clog2(TRIGGER_COUNT)-1:0] cfgAddress,
    input  logic [7:0]                       cfgCode,
    input  logic [TRIGGER_COUNT-1:0]         cfgOverrunClear,
    output logic [TRIGGER_COUNT-1:0]         overrun,
    output logic [7:0]                       evgHardwareEventTDATA,
    output logic                             evgHardwareEventTVALID,
    input  logic                             evgHardwareEventTREADY
);
    localparam int AW = $clog2(TRIGGER_COUNT);

    logic [TRIGGER_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [TRIGGER_COUNT-1:0] delayed, edge_q, pending, enabled, gnt_vec, ovr_set;
    logic [7:0]               code_table [TRIGGER_COUNT];
    logic [AW-1:0]            ptr, grant, idx;
    logic                     found, free;

    // Round-robin search starts one past the last grant and wraps.
    always_comb begin
        enabled = '0;
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < TRIGGER_COUNT; i++)
            enabled[i] = code_table[i] != 8'h00;
        for (int k = 1; k <= TRIGGER_COUNT; k++) begin
            idx = AW'((int'(ptr) + k) % TRIGGER_COUNT);
            if (!found && pending[idx] && enabled[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        free    = !evgHardwareEventTVALID || evgHardwareEventTREADY;
        gnt_vec = (free && found) ? ({{(TRIGGER_COUNT-1){1'b0}}, 1'b1} << grant) : '0;
        ovr_set = edge_q & enabled & pending & ~gnt_vec;
    end

    always_ff @(posedge evgTxClk) begin
        if (evgTxReset) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
            for (int i = 0; i < TRIGGER_COUNT; i++)
                code_table[i] <= 8'h00;
            delayed                <= '0;
            edge_q                 <= '0;
            pending                <= '0;
            overrun                <= '0;
            ptr                    <= AW'(TRIGGER_COUNT - 1);
            evgHardwareEventTDATA  <= 8'h00;
            evgHardwareEventTVALID <= 1'b0;
        end else begin
            sync_q[0] <= triggers;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
            delayed <= sync_q[SYNC_STAGES-1];
            edge_q  <= sync_q[SYNC_STAGES-1] & ~delayed;
            pending <= ((pending & ~gnt_vec) | edge_q) & enabled;
            overrun <= (overrun & ~cfgOverrunClear) | ovr_set;
            if (cfgWrite && int'(cfgAddress) < TRIGGER_COUNT)
                code_table[cfgAddress] <= cfgCode;
            if (free) begin
                evgHardwareEventTVALID <= found;
                if (found) begin
                    evgHardwareEventTDATA <= code_table[grant];
                    ptr                   <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_evg_hw_event_encoder.sv
// tb_evg_hw_event_encoder: directed stimulus with a scoreboard queue of expected
// event codes, popped by a monitor on every accepted output transfer.
module tb_evg_hw_event_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] triggers = '0;
    logic       cfg_write = 1'b0;
    logic [2:0] cfg_address = '0;
    logic [7:0] cfg_code = '0;
    logic [7:0] cfg_overrun_clear = '0;
    logic [7:0] overrun;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b1;

    logic [7:0] exp_q [$];
    logic [7:0] exp_code;
    int         compared = 0;
    int         mismatched = 0;

    evg_hw_event_encoder #(.TRIGGER_COUNT(8), .SYNC_STAGES(2)) dut (
        .evgTxClk(clk),
        .evgTxReset(rst),
        .triggers(triggers),
        .cfgWrite(cfg_write),
        .cfgAddress(cfg_address),
        .cfgCode(cfg_code),
        .cfgOverrunClear(cfg_overrun_clear),
        .overrun(overrun),
        .evgHardwareEventTDATA(tdata),
        .evgHardwareEventTVALID(tvalid),
        .evgHardwareEventTREADY(tready)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] addr, input logic [7:0] code);
        cfg_write   = 1'b1;
        cfg_address = addr;
        cfg_code    = code;
        tick(1);
        cfg_write = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] mask);
        triggers = mask;
        tick(2);
        triggers = '0;
        tick(2);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tvalid && n < 20) begin
            tick(1);
            n++;
        end
        check(name, {31'b0, tvalid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_output: got %0h expected none", tdata);
                    end else begin
                        exp_code = exp_q.pop_front();
                        check("scoreboard_code", {24'b0, tdata}, {24'b0, exp_code});
                    end
                end
            end
        join_none

        tick(3);
        rst = 1'b0;
        check("reset_tvalid", {31'b0, tvalid}, 32'd0);
        check("reset_tdata", {24'b0, tdata}, 32'h00);
        check("reset_overrun", {24'b0, overrun}, 32'h00);

        // Single pulse: latency and one-cycle valid
        cfg(3'd3, 8'h2A);
        exp_q.push_back(8'h2A);
        triggers = 8'h08;
        tick(2);
        triggers = '0;
        tick(2);
        check("latency_not_yet", {31'b0, tvalid}, 32'd0);
        tick(1);
        check("latency_valid", {31'b0, tvalid}, 32'd1);
        check("latency_data", {24'b0, tdata}, 32'h2A);
        tick(1);
        check("single_request", {31'b0, tvalid}, 32'd0);
        check("no_overrun_single", {24'b0, overrun}, 32'h00);

        // Round robin, back-to-back
        cfg(3'd0, 8'h10);
        cfg(3'd1, 8'h11);
        cfg(3'd2, 8'h12);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        triggers = 8'h07;
        tick(2);
        triggers = '0;
        wait_valid("rr1_wait");
        check("rr1_first", {24'b0, tdata}, 32'h10);
        tick(1);
        check("rr1_b2b_valid2", {31'b0, tvalid}, 32'd1);
        check("rr1_second", {24'b0, tdata}, 32'h11);
        tick(1);
        check("rr1_b2b_valid3", {31'b0, tvalid}, 32'd1);
        check("rr1_third", {24'b0, tdata}, 32'h12);
        tick(1);
        check("rr1_done", {31'b0, tvalid}, 32'd0);

        exp_q.push_back(8'h11);
        pulse(8'h02);
        tick(8);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        pulse(8'h07);
        tick(10);

        // Backpressure: presented code stays stable
        cfg(3'd5, 8'h55);
        tready = 1'b0;
        triggers = 8'h08;
        tick(2);
        triggers = '0;
        wait_valid("bp_wait");
        for (int i = 0; i < 12; i++) begin
            if (i == 1) triggers = 8'h28;
            if (i == 3) triggers = 8'h00;
            check("bp_stable_valid", {31'b0, tvalid}, 32'd1);
            check("bp_stable_data", {24'b0, tdata}, 32'h2A);
            tick(1);
        end
        check("bp_no_overrun", {24'b0, overrun}, 32'h00);
        exp_q.push_back(8'h2A);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h2A);
        tready = 1'b1;
        tick(10);
        check("bp_drained", {31'b0, tvalid}, 32'd0);

        // Overrun on a blocked, already pending trigger
        tready = 1'b0;
        pulse(8'h08);
        wait_valid("ovr_wait");
        pulse(8'h08);
        pulse(8'h08);
        tick(6);
        check("ovr_set", {24'b0, overrun}, 32'h08);
        check("ovr_held_data", {24'b0, tdata}, 32'h2A);
        exp_q.push_back(8'h2A);
        exp_q.push_back(8'h2A);
        tready = 1'b1;
        tick(8);
        check("ovr_drained", {31'b0, tvalid}, 32'd0);
        check("ovr_sticky", {24'b0, overrun}, 32'h08);
        cfg_overrun_clear = 8'h08;
        tick(1);
        cfg_overrun_clear = '0;
        check("ovr_cleared", {24'b0, overrun}, 32'h00);

        // Disabled trigger, then enabled
        pulse(8'h40);
        tick(8);
        check("disabled_no_valid", {31'b0, tvalid}, 32'd0);
        check("disabled_no_overrun", {24'b0, overrun}, 32'h00);
        cfg(3'd6, 8'h66);
        exp_q.push_back(8'h66);
        pulse(8'h40);
        tick(8);

        // Reset with a presented code and pending requests
        tready = 1'b0;
        pulse(8'h0F);
        wait_valid("rst_wait");
        pulse(8'h02);
        tick(4);
        check("pre_rst_data", {24'b0, tdata}, 32'h10);
        check("pre_rst_overrun", {24'b0, overrun}, 32'h02);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("post_rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("post_rst_tdata", {24'b0, tdata}, 32'h00);
        check("post_rst_overrun", {24'b0, overrun}, 32'h00);
        tready = 1'b1;
        tick(4);
        pulse(8'h08);
        tick(10);
        check("post_rst_table_cleared", {31'b0, tvalid}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/evg_hw_event_encoder.md
Name: evg_hw_event_encoder

Overview:
Upstream stage for the event generator core's hardware-event AXI-stream input. It synchronizes TRIGGER_COUNT asynchronous external trigger lines and detects rising edges. Each edge is queued as one pending request per line and mapped through a run-time programmable code table. Pending requests are arbitrated round-robin and presented as an 8-bit event code on evgHardwareEventTDATA/TVALID, consumed by the core when evgHardwareEventTREADY is high.

Parameters:
TRIGGER_COUNT, 8, number of external trigger inputs (2..32)
SYNC_STAGES, 2, synchronizer flip-flops per trigger before edge detection (>=2)

Ports:
evgTxClk  input  1  transmitter clock; sole clock of block
evgTxReset  input  1  synchronous, active-high reset
triggers  input  TRIGGER_COUNT  asynchronous trigger lines, rising-edge active
cfgWrite  input  1  one-cycle strobe: write cfgCode into table entry cfgAddress
cfgAddress  input  $clog2(TRIGGER_COUNT)  table index; values >= TRIGGER_COUNT ignored
cfgCode  input  8  event code for that trigger; 8'h00 disables the trigger
cfgOverrunClear  input  TRIGGER_COUNT  per-bit clear of sticky overrun flags
overrun  output  TRIGGER_COUNT  sticky: edge arrived while that trigger already pending
evgHardwareEventTDATA  output  8  event code presented to core
evgHardwareEventTVALID  output  1  code valid
evgHardwareEventTREADY  input  1  core accepts code this cycle

Behaviour:
- Interface: one clock, evgTxClk; reset evgTxReset is synchronous and active-high.
- Reset clears the following: synchronizer/edge registers, pending bits, overrun, TDATA=8'h00, TVALID=0, and all table entries (set to 8'h00, so all triggers are disabled). The round-robin pointer is set to TRIGGER_COUNT-1 so index 0 wins first. Reset has priority over every other action; in-flight TVALID is dropped.
- Sync: each trigger passes through SYNC_STAGES flops, then one delay flop. edge[i] = synced & !delayed.
- Pending: pending[i] is set on the clock after edge[i] if table[i] != 0. Edges on disabled triggers are discarded and never set overrun. Pending bits whose table entry is (or becomes) 0 are cleared on the next clock.
- Overrun: edge[i] while pending[i] is set and not being granted in the same cycle sets overrun[i]. Pending stays set (one request, no counting).
- Edge on i in the same cycle pending[i] is granted: pending[i] stays set for a new request; no overrun.
- Output register is "free" when TVALID==0 or (TVALID && TREADY).
- When free and any eligible pending bit exists, grant the first set index searching from pointer+1 upward, wrapping modulo TRIGGER_COUNT. On the next clock: TDATA=table[grant], TVALID=1, pending[grant] cleared, pointer=grant.
- When free and nothing is pending, TVALID goes to 0 on the next clock. TDATA holds its last value.
- Back-to-back: with TREADY held high and requests pending, one code is issued per clock.
- While TVALID && !TREADY, TDATA and TVALID are held stable (AXI-stream rule). A table write to the presented entry does not alter TDATA.
- The code is read from the table at grant time, so a write that lands before the grant takes effect.
- Latency with SYNC_STAGES=2, idle block and TREADY=1: trigger first sampled high at edge 0 → pending at edge 3 → TVALID=1 after edge 4.
- cfgWrite and cfgOverrunClear act on the next clock. If an overrun set and a clear hit the same bit in the same cycle, set wins.
- Triggers held high produce exactly one request; the line must return low, then high, to request again.

Test Plan:
- Reset, table[3]=8'h2A, pulse triggers[3] for 2 clocks, TREADY=1 → TVALID high exactly 1 clock, TDATA=8'h2A, 4 clocks after first sample; overrun=0.
- table[0..2]=8'h10,8'h11,8'h12; edge all three simultaneously; TREADY=1 → codes 10,11,12 on consecutive clocks. Repeat with pointer left at 1 → order 12,10,11.
- TREADY=0 with 8'h2A presented for 10 clocks, then a second edge on trigger 3 and an edge on trigger 5 (8'h55) → TDATA/TVALID stable throughout; overrun[3] stays 0 (3 not pending). After TREADY=1: 2A, then 55, then 2A.
- Trigger 3 pending and blocked (TREADY=0), two further edges → overrun[3]=1 and only one extra 8'h2A issued. Then cfgOverrunClear[3] → overrun[3]=0 next clock.
- table[6]=0, edge on 6 → no TVALID, no overrun. Set table[6]=8'h66 while trigger 6 idle, then edge → 8'h66 issued.
- Assert evgTxReset while TVALID=1 and 3 requests pending → next clock TVALID=0, TDATA=0, pending/overrun clear. A subsequent edge on a previously enabled trigger issues nothing, because the table has been reset.
